// File: rtl/soc_bus_decoder.sv
// Address decoder bridging one master to four slaves (MEM, UART, TIMER, GPIO) with a response timeout.
// Latency: request and grant pass through combinationally; the response is forwarded in the cycle it arrives.
// Backpressure: the master holds its request until the selected slave grants; only one transaction is in flight.
//
// Ports: clk_i / rst_ni            clock, synchronous active-low reset
//        m_req_i .. m_be_i         master request (address, write data, byte enables)
//        m_gnt_o .. m_err_o        master grant and one-cycle response (error flagged on unmapped or timeout)
//        s_req_o .. s_be_o         one-hot slave request, window offset address, forwarded write fields
//        s_gnt_i .. s_rdata_i      per-slave grant, response valid and read data
module soc_bus_decoder #(
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
    parameter logic [31:0] UART_BASE  = 32'h0010_0000,
    parameter logic [31:0] TIMER_BASE = 32'h0020_0000,
    parameter logic [31:0] GPIO_BASE  = 32'h0040_0000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             m_req_i,
    input  logic             m_we_i,
    input  logic [31:0]      m_addr_i,
    input  logic [31:0]      m_wdata_i,
    input  logic [3:0]       m_be_i,
    output logic             m_gnt_o,
    output logic             m_rvalid_o,
    output logic [31:0]      m_rdata_o,
    output logic             m_err_o,
    output logic [3:0]       s_req_o,
    output logic [31:0]      s_addr_o,
    output logic             s_we_o,
    output logic [31:0]      s_wdata_o,
    output logic [3:0]       s_be_o,
    input  logic [3:0]       s_gnt_i,
    input  logic [3:0]       s_rvalid_i,
    input  logic [3:0][31:0] s_rdata_i
);

    localparam logic [7:0] TO_LIM = TIMEOUT[7:0];

    // Window ends are computed one bit wider so a window touching the top of
    // the address space cannot wrap around.
    localparam logic [32:0] MEM_END   = {1'b0, MEM_BASE}   + 33'h0_0002_8000;
    localparam logic [32:0] UART_END  = {1'b0, UART_BASE}  + 33'h0_0000_0010;
    localparam logic [32:0] TIMER_END = {1'b0, TIMER_BASE} + 33'h0_0000_0010;
    localparam logic [32:0] GPIO_END  = {1'b0, GPIO_BASE}  + 33'h0_0000_0010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        RESP     = 2'd2,
        ERR      = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_sel;
    logic [7:0]  r_cnt;
    logic        r_live;     // low during reset and the first cycle after it

    logic [32:0] w_addr_x;
    logic [3:0]  w_hit;
    logic        w_any_hit;
    logic [1:0]  w_sel;
    logic [31:0] w_base;
    logic [7:0]  w_cnt_inc;
    logic        w_out_en;

    assign w_addr_x = {1'b0, m_addr_i};

    assign w_hit[0] = (m_addr_i >= MEM_BASE)   && (w_addr_x < MEM_END);
    assign w_hit[1] = (m_addr_i >= UART_BASE)  && (w_addr_x < UART_END);
    assign w_hit[2] = (m_addr_i >= TIMER_BASE) && (w_addr_x < TIMER_END);
    assign w_hit[3] = (m_addr_i >= GPIO_BASE)  && (w_addr_x < GPIO_END);
    assign w_any_hit = |w_hit;

    always_comb begin
        w_sel  = 2'd0;
        w_base = MEM_BASE;
        if (w_hit[1]) begin
            w_sel  = 2'd1;
            w_base = UART_BASE;
        end else if (w_hit[2]) begin
            w_sel  = 2'd2;
            w_base = TIMER_BASE;
        end else if (w_hit[3]) begin
            w_sel  = 2'd3;
            w_base = GPIO_BASE;
        end
    end

    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_out_en  = rst_ni & r_live;

    assign s_addr_o  = w_any_hit ? (m_addr_i - w_base) : m_addr_i;
    assign s_we_o    = m_we_i;
    assign s_wdata_o = m_wdata_i;
    assign s_be_o    = m_be_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_cnt   <= 8'd0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                // WAIT_GNT behaves like IDLE: the slave is re-decoded every cycle.
                IDLE, WAIT_GNT: begin
                    if (r_live && m_req_i) begin
                        if (w_any_hit) begin
                            if (s_gnt_i[w_sel]) begin
                                r_state <= RESP;
                                r_sel   <= w_sel;
                                r_cnt   <= 8'd0;
                            end else begin
                                r_state <= WAIT_GNT;
                            end
                        end else begin
                            r_state <= ERR;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RESP: begin
                    // A response arriving in the cycle the limit is reached wins.
                    if (s_rvalid_i[r_sel]) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == TO_LIM) begin
                            r_state <= ERR;
                        end
                    end
                end
                ERR: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        m_gnt_o    = 1'b0;
        m_rvalid_o = 1'b0;
        m_err_o    = 1'b0;
        m_rdata_o  = 32'd0;
        s_req_o    = 4'd0;
        case (r_state)
            IDLE, WAIT_GNT: begin
                if (w_out_en && m_req_i) begin
                    if (w_any_hit) begin
                        s_req_o[w_sel] = 1'b1;
                        m_gnt_o        = s_gnt_i[w_sel];
                    end else begin
                        m_gnt_o = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rst_ni && s_rvalid_i[r_sel]) begin
                    m_rvalid_o = 1'b1;
                    m_rdata_o  = s_rdata_i[r_sel];
                end
            end
            ERR: begin
                if (rst_ni) begin
                    m_rvalid_o = 1'b1;
                    m_err_o    = 1'b1;
                end
            end
            default: begin
                m_gnt_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_soc_bus_decoder.sv
module tb_soc_bus_decoder;

    localparam int unsigned TO = 4;
    localparam logic [31:0] WBASE [4] = '{32'h0000_0000, 32'h0010_0000, 32'h0020_0000, 32'h0040_0000};
    localparam logic [31:0] WSIZE [4] = '{32'h0002_8000, 32'h0000_0010, 32'h0000_0010, 32'h0000_0010};

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             m_req_i;
    logic             m_we_i;
    logic [31:0]      m_addr_i;
    logic [31:0]      m_wdata_i;
    logic [3:0]       m_be_i;
    logic             m_gnt_o;
    logic             m_rvalid_o;
    logic [31:0]      m_rdata_o;
    logic             m_err_o;
    logic [3:0]       s_req_o;
    logic [31:0]      s_addr_o;
    logic             s_we_o;
    logic [31:0]      s_wdata_o;
    logic [3:0]       s_be_o;
    logic [3:0]       s_gnt_i;
    logic [3:0]       s_rvalid_i;
    logic [3:0][31:0] s_rdata_i;

    always #5 clk_i = ~clk_i;

    soc_bus_decoder #(.TIMEOUT(TO)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .m_req_i    (m_req_i),
        .m_we_i     (m_we_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_be_i     (m_be_i),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_addr_o   (s_addr_o),
        .s_we_o     (s_we_o),
        .s_wdata_o  (s_wdata_o),
        .s_be_o     (s_be_o),
        .s_gnt_i    (s_gnt_i),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sreq;
        logic [31:0] saddr;
        logic        unm;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // {gnt, rvalid, err, s_req, rdata}
    function automatic logic [63:0] ex(input logic g, input logic rv, input logic er,
                                       input logic [3:0] sr, input logic [31:0] rd);
        return {25'd0, g, rv, er, sr, rd};
    endfunction

    function automatic logic [63:0] outv();
        return {25'd0, m_gnt_o, m_rvalid_o, m_err_o, s_req_o, m_rdata_o};
    endfunction

    function automatic void ref_decode(input logic [31:0] a, output int idx, output logic [31:0] off);
        idx = -1;
        off = a;
        for (int i = 0; i < 4; i++) begin
            if (a >= WBASE[i] && (a - WBASE[i]) < WSIZE[i]) begin
                idx = i;
                off = a - WBASE[i];
            end
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        int w;
        logic [31:0] o;
        if ($urandom_range(0, 4) == 0) return $urandom;
        w = $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 1) o = $urandom_range(0, WSIZE[w] - 1);
        else o = WSIZE[w] - 32'd2 + $urandom_range(0, 3);
        return WBASE[w] + o;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic look();
        @(negedge clk_i);
    endtask

    task automatic idle_in();
        m_req_i    = 1'b0;
        m_we_i     = 1'b0;
        m_addr_i   = 32'd0;
        m_wdata_i  = 32'd0;
        m_be_i     = 4'd0;
        s_gnt_i    = 4'd0;
        s_rvalid_i = 4'd0;
        s_rdata_i  = '0;
    endtask

    task automatic noise();
        s_gnt_i    = 4'($urandom);
        s_rvalid_i = 4'($urandom);
        for (int i = 0; i < 4; i++) s_rdata_i[i] = $urandom;
    endtask

    initial begin
        int          idx;
        logic [31:0] off;
        logic [31:0] a;
        logic [3:0]  oh;
        int          gd;
        int          rd;
        bit          drop;
        int          drop_at;
        bit          accepted;

        tbl[0]  = '{32'h0001_0000, 4'b0001, 32'h0001_0000, 1'b0};
        tbl[1]  = '{32'h0000_0000, 4'b0001, 32'h0000_0000, 1'b0};
        tbl[2]  = '{32'h0002_7FFF, 4'b0001, 32'h0002_7FFF, 1'b0};
        tbl[3]  = '{32'h0002_8000, 4'b0000, 32'h0000_0000, 1'b1};
        tbl[4]  = '{32'h0003_0000, 4'b0000, 32'h0000_0000, 1'b1};
        tbl[5]  = '{32'h0010_0000, 4'b0010, 32'h0000_0000, 1'b0};
        tbl[6]  = '{32'h0010_000F, 4'b0010, 32'h0000_000F, 1'b0};
        tbl[7]  = '{32'h0010_0010, 4'b0000, 32'h0000_0000, 1'b1};
        tbl[8]  = '{32'h000F_FFFF, 4'b0000, 32'h0000_0000, 1'b1};
        tbl[9]  = '{32'h0020_0004, 4'b0100, 32'h0000_0004, 1'b0};
        tbl[10] = '{32'h0020_000F, 4'b0100, 32'h0000_000F, 1'b0};
        tbl[11] = '{32'h0040_000C, 4'b1000, 32'h0000_000C, 1'b0};
        tbl[12] = '{32'h0040_0010, 4'b0000, 32'h0000_0000, 1'b1};
        tbl[13] = '{32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 1'b1};

        // Reset with an active request and eager slaves: nothing may leak out.
        idle_in();
        rst_ni     = 1'b0;
        m_req_i    = 1'b1;
        m_addr_i   = 32'h0010_0000;
        s_gnt_i    = 4'hF;
        s_rvalid_i = 4'hF;
        look(); chk("reset_hold", outv(), 64'd0); tick();
        look(); chk("reset_hold2", outv(), 64'd0); tick();
        rst_ni = 1'b1;
        look(); chk("first_after_reset", outv(), 64'd0); tick();
        idle_in();
        s_gnt_i    = 4'hF;
        s_rvalid_i = 4'hF;
        look(); chk("idle_quiet", outv(), 64'd0); tick();

        // MEM read, immediate grant, data two cycles later.
        idle_in();
        m_req_i  = 1'b1;
        m_addr_i = 32'h0001_0000;
        s_gnt_i  = 4'b0001;
        look();
        chk("mem_grant", outv(), ex(1, 0, 0, 4'b0001, 0));
        chk("mem_saddr", s_addr_o, 32'h0001_0000);
        tick();
        idle_in();
        s_rvalid_i   = 4'b1110;
        s_rdata_i[1] = 32'h1111_1111;
        look(); chk("mem_wait_ignore_others", outv(), 64'd0); tick();
        idle_in();
        s_rvalid_i   = 4'b0001;
        s_rdata_i[0] = 32'hA5A5_A5A5;
        s_rdata_i[1] = 32'h1234_5678;
        look(); chk("mem_resp", outv(), ex(0, 1, 0, 0, 32'hA5A5_A5A5)); tick();
        idle_in();
        look(); chk("mem_after", outv(), 64'd0); tick();

        // TIMER write with grant delayed by three cycles.
        idle_in();
        m_req_i   = 1'b1;
        m_we_i    = 1'b1;
        m_addr_i  = 32'h0020_0004;
        m_wdata_i = 32'hDEAD_BEEF;
        m_be_i    = 4'b0110;
        for (int c = 0; c < 4; c++) begin
            s_gnt_i = (c == 3) ? 4'b0100 : 4'b1011;
            look();
            chk("timer_req", outv(), ex(c == 3, 0, 0, 4'b0100, 0));
            chk("timer_saddr", s_addr_o, 32'h4);
            tick();
        end
        chk("timer_fwd", {s_we_o, s_be_o, s_wdata_o}, {1'b1, 4'b0110, 32'hDEAD_BEEF});
        idle_in();
        s_rvalid_i   = 4'b0100;
        s_rdata_i[2] = 32'h0000_0001;
        look(); chk("timer_resp", outv(), ex(0, 1, 0, 0, 32'h1)); tick();

        // Unmapped read, request held through the error cycle.
        idle_in();
        m_req_i  = 1'b1;
        m_addr_i = 32'h0003_0000;
        s_gnt_i  = 4'hF;
        look(); chk("unm_gnt", outv(), ex(1, 0, 0, 0, 0)); tick();
        look(); chk("unm_err", outv(), ex(0, 1, 1, 0, 0)); tick();
        idle_in();
        look(); chk("unm_after", outv(), 64'd0); tick();

        // GPIO grants but never answers.
        idle_in();
        m_req_i  = 1'b1;
        m_addr_i = 32'h0040_0008;
        s_gnt_i  = 4'b1000;
        look(); chk("tmo_gnt", outv(), ex(1, 0, 0, 4'b1000, 0)); tick();
        for (int k = 1; k <= TO; k++) begin
            idle_in();
            s_rvalid_i = 4'b0111;
            look(); chk("tmo_wait", outv(), 64'd0); tick();
        end
        idle_in();
        look(); chk("tmo_err", outv(), ex(0, 1, 1, 0, 0)); tick();
        idle_in();
        s_rvalid_i   = 4'b1000;
        s_rdata_i[3] = 32'hCAFE_0001;
        look(); chk("tmo_late_ignored", outv(), 64'd0); tick();

        // Response on the very cycle the limit is reached.
        idle_in();
        m_req_i  = 1'b1;
        m_addr_i = 32'h0040_0000;
        s_gnt_i  = 4'b1000;
        look(); chk("race_gnt", outv(), ex(1, 0, 0, 4'b1000, 0)); tick();
        for (int k = 1; k < TO; k++) begin
            idle_in();
            look(); chk("race_wait", outv(), 64'd0); tick();
        end
        idle_in();
        s_rvalid_i   = 4'b1000;
        s_rdata_i[3] = 32'h0BAD_F00D;
        look(); chk("race_resp", outv(), ex(0, 1, 0, 0, 32'h0BAD_F00D)); tick();
        idle_in();
        look(); chk("race_no_err", outv(), 64'd0); tick();

        // Request withdrawn while waiting for grant.
        idle_in();
        m_req_i  = 1'b1;
        m_addr_i = 32'h0010_0004;
        for (int c = 0; c < 2; c++) begin
            look(); chk("drop_wait", outv(), ex(0, 0, 0, 4'b0010, 0)); tick();
        end
        idle_in();
        s_gnt_i = 4'b0010;
        look(); chk("drop_now", outv(), 64'd0); tick();
        for (int c = 0; c < 2; c++) begin
            idle_in();
            s_rvalid_i = 4'hF;
            look(); chk("drop_no_resp", outv(), 64'd0); tick();
        end

        // Reset while a response is pending, then a clean UART read.
        idle_in();
        m_req_i  = 1'b1;
        m_addr_i = 32'h0010_0000;
        s_gnt_i  = 4'b0010;
        look(); chk("rst_resp_gnt", outv(), ex(1, 0, 0, 4'b0010, 0)); tick();
        idle_in();
        rst_ni       = 1'b0;
        s_rvalid_i   = 4'b0010;
        s_rdata_i[1] = 32'h7777_7777;
        look(); chk("rst_in_resp", outv(), 64'd0); tick();
        idle_in();
        rst_ni     = 1'b1;
        s_rvalid_i = 4'b0010;
        look(); chk("rst_in_resp_after", outv(), 64'd0); tick();
        idle_in();
        m_req_i  = 1'b1;
        m_addr_i = 32'h0010_0008;
        s_gnt_i  = 4'b0010;
        look();
        chk("uart_gnt", outv(), ex(1, 0, 0, 4'b0010, 0));
        chk("uart_saddr", s_addr_o, 32'h8);
        tick();
        idle_in();
        s_rvalid_i   = 4'b0010;
        s_rdata_i[1] = 32'h5A5A_0102;
        look(); chk("uart_resp", outv(), ex(0, 1, 0, 0, 32'h5A5A_0102)); tick();

        // Decode table.
        foreach (tbl[i]) begin
            idle_in();
            m_req_i  = 1'b1;
            m_addr_i = tbl[i].addr;
            look();
            chk("tbl_req", outv(), ex(tbl[i].unm, 0, 0, tbl[i].sreq, 0));
            if (!tbl[i].unm) chk("tbl_saddr", s_addr_o, tbl[i].saddr);
            tick();
            idle_in();
            look(); chk("tbl_next", outv(), ex(0, tbl[i].unm, tbl[i].unm, 0, 0)); tick();
            look(); chk("tbl_idle", outv(), 64'd0); tick();
        end

        // Random back-to-back transactions with noisy slaves.
        for (int t = 0; t < 300; t++) begin
            a = rand_addr();
            ref_decode(a, idx, off);
            gd       = $urandom_range(0, 3);
            rd       = $urandom_range(0, 5);
            drop     = ($urandom_range(0, 7) == 0) && (gd > 0);
            drop_at  = drop ? $urandom_range(1, gd) : 0;
            accepted = 1'b1;
            m_addr_i  = a;
            m_we_i    = 1'($urandom);
            m_wdata_i = $urandom;
            m_be_i    = 4'($urandom);
            if (idx < 0) begin
                m_req_i = 1'b1;
                noise();
                look(); chk("rnd_unm_gnt", outv(), ex(1, 0, 0, 0, 0)); tick();
                m_req_i = 1'($urandom);
                noise();
                look(); chk("rnd_unm_err", outv(), ex(0, 1, 1, 0, 0)); tick();
            end else begin
                oh = 4'b0001 << idx;
                for (int c = 0; c <= gd; c++) begin
                    noise();
                    s_gnt_i[idx] = (c == gd);
                    m_req_i      = !(drop && c == drop_at);
                    look();
                    if (drop && c == drop_at) begin
                        chk("rnd_drop", outv(), 64'd0);
                        accepted = 1'b0;
                        tick();
                        break;
                    end
                    chk("rnd_req", outv(), ex(c == gd, 0, 0, oh, 0));
                    chk("rnd_saddr", s_addr_o, off);
                    chk("rnd_fwd", {s_we_o, s_be_o, s_wdata_o}, {m_we_i, m_be_i, m_wdata_i});
                    tick();
                end
                if (accepted) begin
                    for (int k = 1; k <= TO; k++) begin
                        noise();
                        m_req_i         = 1'($urandom);
                        s_rvalid_i[idx] = (k == rd + 1);
                        look();
                        if (k == rd + 1) begin
                            chk("rnd_resp", outv(), ex(0, 1, 0, 0, s_rdata_i[idx]));
                            tick();
                            break;
                        end
                        chk("rnd_wait", outv(), 64'd0);
                        tick();
                    end
                    if (rd + 1 > TO) begin
                        noise();
                        m_req_i = 1'($urandom);
                        look(); chk("rnd_tmo", outv(), ex(0, 1, 1, 0, 0)); tick();
                    end
                end
            end
        end

        idle_in();
        look(); chk("final_idle", outv(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_bus_decoder.md
SOC_BUS_DECODER -- requirements
Module: soc_bus_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255 (range 1..255): maximum wait, in cycles, for a slave response after grant.
REQ-002 SHALL have parameter MEM_BASE, default 32'h0000_0000, size 32'h0002_8000: data memory window.
REQ-003 SHALL have parameter UART_BASE, default 32'h0010_0000, size 16 bytes.
REQ-004 SHALL have parameter TIMER_BASE, default 32'h0020_0000, size 16 bytes.
REQ-005 SHALL have parameter GPIO_BASE, default 32'h0040_0000, size 16 bytes.
REQ-006 SHALL have these ports, clock and reset first; reset is synchronous and active-low:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  synchronous active-low reset
- m_req_i  in  1  master request
- m_we_i  in  1  master write enable
- m_addr_i  in  32  master byte address
- m_wdata_i  in  32  master write data
- m_be_i  in  4  master byte enables
- m_gnt_o  out  1  request accepted
- m_rvalid_o  out  1  response valid, one cycle
- m_rdata_o  out  32  response read data
- m_err_o  out  1  error response, qualified by m_rvalid_o
- s_req_o  out  4  one-hot slave request; bit 0 MEM, 1 UART, 2 TIMER, 3 GPIO
- s_addr_o  out  32  address offset within the selected window (m_addr_i minus base)
- s_we_o  out  1, s_wdata_o  out  32, s_be_o  out  4: forwarded unchanged
- s_gnt_i  in  4  per-slave grant
- s_rvalid_i  in  4  per-slave response valid
- s_rdata_i  in  4x32  per-slave read data

Function
REQ-007 SHALL decode hits as base <= addr < base+size, using unsigned 32-bit compare; no hit means unmapped.
REQ-008 SHALL implement FSM with states IDLE, WAIT_GNT, RESP, ERR.
REQ-009 IDLE/WAIT_GNT with m_req_i=1 and a hit: drive s_req_o one-hot to the hit slave combinationally, and set m_gnt_o = s_gnt_i[sel].
- on grant: latch sel, go to RESP
- otherwise: stay (WAIT_GNT); sel SHALL be re-decoded every cycle
REQ-010 IDLE with m_req_i=1 and no hit: m_gnt_o=1 in the same cycle, s_req_o=0, go to ERR.
REQ-011 ERR: m_rvalid_o=1, m_err_o=1, m_rdata_o=0 for exactly one cycle, then IDLE.
REQ-012 RESP: m_rvalid_o = s_rvalid_i[sel] and m_rdata_o = s_rdata_i[sel], same cycle (zero added latency), m_err_o=0; go to IDLE on that cycle.
- s_rvalid_i bits of unselected slaves SHALL be ignored.
REQ-013 Exactly one outstanding transaction: m_gnt_o=0 and s_req_o=0 in RESP and ERR; back-to-back requests are accepted earliest in the cycle after the response.
REQ-014 Timeout: an 8-bit counter clears on grant and increments each RESP cycle without s_rvalid_i[sel]. On reaching TIMEOUT, it SHALL go to ERR.
- a later s_rvalid_i from that slave SHALL be ignored in IDLE.
REQ-015 s_rvalid_i[sel] in the same cycle the counter reaches TIMEOUT: the valid response wins, with no error.
REQ-016 m_req_i dropped in WAIT_GNT: s_req_o=0, return to IDLE, no response.
REQ-017 Outputs m_rvalid_o, m_err_o and s_req_o SHALL be 0 in IDLE when m_req_i=0; m_rdata_o SHALL be 0 whenever m_rvalid_o=0.

Reset
REQ-018 rst_ni=0 at a rising edge SHALL force IDLE, clear the counter and sel, and drop any in-flight transaction, with no response issued.
REQ-019 During reset and the first cycle after it, m_gnt_o, m_rvalid_o, m_err_o and s_req_o SHALL be 0.

Verification
REQ-020 Read 0x0001_0000, MEM grants immediately, rvalid 2 cycles later with 0xA5A5_A5A5 -> s_req_o=4'b0001, s_addr_o=0x0001_0000, m_rdata_o=0xA5A5_A5A5, m_err_o=0.
REQ-021 Write 0x0020_0004, TIMER grant delayed 3 cycles -> s_req_o=4'b0100 held for 4 cycles, s_addr_o=0x4, m_gnt_o asserted in the 4th cycle.
REQ-022 Read 0x0003_0000 (unmapped) -> m_gnt_o=1 in the same cycle; next cycle m_rvalid_o=1, m_err_o=1, m_rdata_o=0; s_req_o stays 0.
REQ-023 TIMEOUT=4, GPIO grants but never responds -> m_rvalid_o=1 with m_err_o=1 after 4 RESP cycles; a late s_rvalid_i[3] is ignored.
REQ-024 Boundary addresses -> 0x0002_7FFF hits MEM; 0x0010_000F hits UART; 0x0010_0010 is unmapped.
REQ-025 rst_ni=0 while in RESP -> IDLE next cycle, no m_rvalid_o; a new request to UART then completes normally.
